// File: rtl/fp_alu_pkg.sv
// Shared types for the floating-point ALU datapath helpers.
package fp_alu_pkg;

    // Operation select for the two's-complement unit; 2'b11 falls back to pass.
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10
    } twos_mode_t;

    // Chunk-serial sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } twos_state_t;

endpackage

// File: rtl/twos_negate_seq_if.sv
// Operand/result handshake bundle for twos_negate_seq.
interface twos_negate_seq_if #(
    parameter int unsigned WIDTH = 24
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_zero;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_zero
    );

    // Unit side.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_zero
    );
endinterface

// File: rtl/twos_chunk_inc.sv
// One chunk of the serial negator: optional invert, then add the incoming carry.
module twos_chunk_inc #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] d,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK-1:0] x;

    // Conditional one's complement followed by a carry-in increment.
    always_comb begin
        x           = inv ? ~d : d;
        {cout, s}   = {1'b0, x} + {{CHUNK{1'b0}}, cin};
    end
endmodule

// File: rtl/twos_negate_seq.sv
// Chunk-serial pass/negate/abs unit: one CHUNK-bit slice per cycle, carry held in a flop.
module twos_negate_seq
    import fp_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    twos_negate_seq_if.slave bus,
    output logic             busy
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("twos_negate_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    twos_state_t                  state_q, state_d;
    logic [IDXW-1:0]              idx_q, idx_d;
    logic                         carry_q, carry_d;
    logic                         do_neg_q, do_neg_d;
    logic [NCHUNK-1:0][CHUNK-1:0] op_q, op_d;
    logic [NCHUNK-1:0][CHUNK-1:0] result_q, result_d;
    logic                         ovf_q, ovf_d;
    logic                         zero_q, zero_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic                         ready_en_q;

    logic [CHUNK-1:0]             sum;
    logic                         cout;
    logic                         accept;
    logic [1:0]                   mode;

    twos_chunk_inc #(
        .CHUNK (CHUNK)
    ) u_inc (
        .d    (op_q[idx_q]),
        .inv  (do_neg_q),
        .cin  (carry_q),
        .s    (sum),
        .cout (cout)
    );

    // Handshake and status outputs decoded from registered state only (plus out_ready).
    always_comb begin
        bus.in_ready  = ready_en_q & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
        bus.out_valid = (state_q == DONE);
        bus.out_data  = result_q;
        bus.out_ovf   = ovf_q;
        bus.out_zero  = zero_q;
        busy          = (state_q != IDLE);
    end

    // Next-state: ripple one chunk per RUN cycle; an accept in IDLE or DONE reloads.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        do_neg_d = do_neg_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        mode     = bus.in_mode;
        accept   = bus.in_valid & bus.in_ready;

        unique case (state_q)
            IDLE: ;
            RUN: begin
                result_d[idx_q] = sum;
                carry_d         = cout;
                idx_d           = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    // Only 100..0 negates to itself with the sign still set.
                    ovf_d   = do_neg_q & op_q[NCHUNK-1][CHUNK-1] & result_d[NCHUNK-1][CHUNK-1];
                    zero_d  = (result_d == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_d     = bus.in_data;
            do_neg_d = (mode == MODE_NEG) | ((mode == MODE_ABS) & bus.in_data[WIDTH-1]);
            carry_d  = do_neg_d;
            idx_d    = '0;
            state_d  = RUN;
        end
    end

    // State, datapath and result registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            do_neg_q   <= 1'b0;
            op_q       <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            do_neg_q   <= do_neg_d;
            op_q       <= op_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            ready_en_q <= 1'b1;
        end
    end
endmodule

// File: doc/twos_negate_seq.md
# twos_negate_seq

Parametrised, chunk-serial two's-complement unit. It supports pass, negate and absolute-value modes, with a valid/ready handshake on both sides. Each cycle it processes one CHUNK-bit slice of the operand, rippling the carry through a register instead of through a combinational chain. This gives the wide mantissa/exponent negation paths in the floating-point ALU a small, timing-friendly block at any width.

## Interface
- WIDTH, 24: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- in_valid  input  1  operand and mode are valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, two's complement.
- in_mode  input  2  operation select: 00 PASS, 01 NEG, 10 ABS, 11 treated as PASS.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  the operand was negated and it was the most-negative value.
- out_zero  output  1  out_data == 0.
- busy  output  1  the FSM is not in IDLE.

## Operation
- NCHUNK = WIDTH/CHUNK.
- FSM states and transitions:
  - IDLE: in_ready=1.
  - On accept (in_valid & in_ready), the block:
    - latches in_data into the operand register;
    - sets do_neg = (mode==NEG) | (mode==ABS & in_data[WIDTH-1]);
    - sets carry = do_neg;
    - sets idx = 0;
    - goes to RUN.
  - RUN, one chunk per cycle:
    - computes {cout, res} = (do_neg ? ~op[idx] : op[idx]) + carry;
    - writes res into result slice idx and sets carry <= cout;
    - increments idx.
    - When idx == NCHUNK-1, the block goes to DONE.
  - DONE: out_valid=1, and out_data/out_ovf/out_zero are held stable until out_ready.
    - On out_ready with in_valid, the block accepts the new operand in the same cycle (in_ready = out_ready) and goes to RUN.
    - On out_ready without in_valid, it goes to IDLE.
- Arithmetic and width rules:
  - The carry out of the top chunk is discarded, so results are modulo 2^WIDTH.
  - PASS leaves carry at 0, and the output equals the input.
  - out_ovf = do_neg & op[WIDTH-1] & result[WIDTH-1], true only for input 100…0. In that case out_data equals the input (natural wrap).
  - out_zero is evaluated on the final result.
  - Negating 0 ripples the carry through all chunks and gives 0, with out_ovf=0.
- Input changes after acceptance are ignored; the operand is captured.
- Reset (rst_n low, asynchronous, at any time, including mid-RUN):
  - the FSM goes to IDLE;
  - idx, carry and do_neg are cleared to 0;
  - out_data=0, out_ovf=0, out_zero=0, out_valid=0, busy=0;
  - in_ready is 0 while rst_n is low and 1 from the first clock edge after release.
  - A partial result is discarded, never emitted.

## Timing
- Latency: out_valid rises NCHUNK clock edges after the accept edge. WIDTH=24, CHUNK=4 gives 6.
- Throughput: one result per NCHUNK+1 cycles with continuous valid/ready.
- With CHUNK==WIDTH, RUN lasts one cycle.
- All outputs are registered; no combinational path from in_* to out_*.
- in_ready is the only output combinationally dependent on an input (out_ready in DONE).

## Structure
- The shared package fp_alu_pkg holds:
  - the mode enum, twos_mode_t: MODE_PASS, MODE_NEG, MODE_ABS;
  - the FSM state enum, twos_state_t: IDLE, RUN, DONE.
- Sub-module twos_chunk_inc: CHUNK-bit conditional inverter plus incrementer (inputs d, inv, cin; outputs s, cout). It is purely combinational and instantiated once.
- The top level holds the FSM, the idx counter ($clog2(NCHUNK) bits, minimum 1), the operand register, the result register and the carry flop.
- An elaboration-time check rejects WIDTH % CHUNK != 0.

## Test plan
- NEG 0x000001 (WIDTH 24, CHUNK 4) -> out_data 0xFFFFFF, ovf 0, zero 0; out_valid exactly 6 edges after accept.
- ABS 0xFFFFF0 -> 0x000010; ABS 0x000123 -> 0x000123; ABS 0x800000 -> 0x800000 with ovf 1.
- NEG 0x000000 -> 0x000000, zero 1, ovf 0; PASS 0xABCDEF -> 0xABCDEF; mode 11 with 0x123456 -> 0x123456.
- Backpressure: hold out_ready low 3 cycles in DONE -> outputs stable and in_ready 0. Then assert out_ready with in_valid (NEG 0x000002) -> accepted the same cycle, and 0xFFFFFE appears 6 edges later.
- Pull rst_n low during RUN at idx 3 -> all outputs 0 immediately. The next NEG 0x00000F -> 0xFFFFF1, with no stale data.
- With WIDTH=8, CHUNK=8: NEG 0x80 -> 0x80, ovf 1, 1-cycle latency. With WIDTH=32, CHUNK=1: NEG 0x00010000 -> 0xFFFF0000 after 32 cycles.
